// File: rtl/sub32_serial_pkg.sv
// Shared types and sizing helpers for the digit-serial subtractor.
package sub_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam int WIDTH_DEF = 32;
    localparam int DIGIT_DEF = 4;
    localparam int NDIG      = WIDTH_DEF / DIGIT_DEF;

    // Digit counter width; a single-digit configuration still needs one bit.
    function automatic int cnt_width(input int ndig);
        if (ndig <= 1) begin
            return 1;
        end else begin
            return $clog2(ndig);
        end
    endfunction

endpackage

// File: rtl/sub32_serial_fs_digit.sv
// DIGIT-bit combinational full-subtract slice: ripple of full adders fed with
// inverted subtrahend and inverted borrow, carries inverted back into borrows.
module fs_digit #(
    parameter int DIGIT = 4
) (
    input  logic [DIGIT-1:0] a,
    input  logic [DIGIT-1:0] b,
    input  logic             bin,
    output logic [DIGIT-1:0] d,
    output logic             bout,
    output logic             bmsb
);

    logic [DIGIT:0] carry_s;

    // Ripple-carry chain of a + ~b + ~bin.
    always_comb begin
        carry_s    = '0;
        d          = '0;
        carry_s[0] = ~bin;
        for (int i = 0; i < DIGIT; i++) begin
            d[i]         = a[i] ^ ~b[i] ^ carry_s[i];
            carry_s[i+1] = (a[i] & ~b[i]) | (a[i] & carry_s[i]) | (~b[i] & carry_s[i]);
        end
        bout = ~carry_s[DIGIT];
        bmsb = ~carry_s[DIGIT-1];
    end

endmodule

// File: rtl/sub32_serial.sv
// Digit-serial subtractor D = A - B - Bin with borrow-out and result flags,
// valid/ready handshakes on both sides, one DIGIT-wide slice per clock.
module sub32_serial
    import sub_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DIGIT = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] D,
    output logic             Bout,
    output logic             zero,
    output logic             neg,
    output logic             ovf
);

    localparam int             ND   = WIDTH / DIGIT;
    localparam int             CW   = cnt_width(ND);
    localparam logic [CW-1:0]  LAST = CW'(ND - 1);

    state_e           state_q;
    logic [CW-1:0]    cnt_q;
    logic             borrow_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] d_q;
    logic [WIDTH-1:0] d_d;
    logic             bout_q;
    logic             zero_q;
    logic             neg_q;
    logic             ovf_q;
    logic             in_ready_q;
    logic             out_valid_q;

    logic [DIGIT-1:0] dig_a_s;
    logic [DIGIT-1:0] dig_b_s;
    logic [DIGIT-1:0] dig_d_s;
    logic             dig_bout_s;
    logic             dig_bmsb_s;

    // Current digit operands and the result with this digit merged in, so the
    // flags at the final digit see the complete difference.
    always_comb begin
        dig_a_s = a_q[int'(cnt_q) * DIGIT +: DIGIT];
        dig_b_s = b_q[int'(cnt_q) * DIGIT +: DIGIT];
        d_d     = d_q;
        d_d[int'(cnt_q) * DIGIT +: DIGIT] = dig_d_s;
    end

    fs_digit #(.DIGIT(DIGIT)) u_fs_digit (
        .a    (dig_a_s),
        .b    (dig_b_s),
        .bin  (borrow_q),
        .d    (dig_d_s),
        .bout (dig_bout_s),
        .bmsb (dig_bmsb_s)
    );

    // Control FSM plus operand, borrow, result and flag registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            borrow_q    <= 1'b0;
            a_q         <= '0;
            b_q         <= '0;
            d_q         <= '0;
            bout_q      <= 1'b0;
            zero_q      <= 1'b0;
            neg_q       <= 1'b0;
            ovf_q       <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        a_q        <= A;
                        b_q        <= B;
                        borrow_q   <= Bin;
                        cnt_q      <= '0;
                        in_ready_q <= 1'b0;
                        state_q    <= RUN;
                    end
                end
                RUN: begin
                    d_q      <= d_d;
                    borrow_q <= dig_bout_s;
                    cnt_q    <= cnt_q + CW'(1);
                    if (cnt_q == LAST) begin
                        bout_q      <= dig_bout_s;
                        ovf_q       <= dig_bmsb_s ^ dig_bout_s;
                        zero_q      <= (d_d == '0);
                        neg_q       <= d_d[WIDTH-1];
                        out_valid_q <= 1'b1;
                        state_q     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign D         = d_q;
    assign Bout      = bout_q;
    assign zero      = zero_q;
    assign neg       = neg_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_sub32_serial.sv
// Drives DIGIT=1, 4 and 32 instances in lockstep and checks them against an
// arithmetic reference model of A - B - Bin.
module tb_sub32_serial;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        out_ready;
    logic [31:0] a_in;
    logic [31:0] b_in;
    logic        bin_in;

    logic        in_ready_w  [3];
    logic        out_valid_w [3];
    logic [31:0] d_w         [3];
    logic        bout_w      [3];
    logic        zero_w      [3];
    logic        neg_w       [3];
    logic        ovf_w       [3];

    logic [31:0] cap_d    [3];
    logic        cap_bout [3];
    logic        cap_zero [3];
    logic        cap_neg  [3];
    logic        cap_ovf  [3];
    int          lat      [3];
    int          nd_e     [3] = '{32, 8, 1};

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        sub32_serial #(
            .WIDTH (32),
            .DIGIT ((g == 0) ? 1 : ((g == 1) ? 4 : 32))
        ) u_dut (
            .clk       (clk),
            .rst       (rst),
            .in_valid  (in_valid),
            .in_ready  (in_ready_w[g]),
            .A         (a_in),
            .B         (b_in),
            .Bin       (bin_in),
            .out_valid (out_valid_w[g]),
            .out_ready (out_ready),
            .D         (d_w[g]),
            .Bout      (bout_w[g]),
            .zero      (zero_w[g]),
            .neg       (neg_w[g]),
            .ovf       (ovf_w[g])
        );
    end

    // Reference: {ovf, neg, zero, bout, d} from plain wide arithmetic.
    function automatic logic [35:0] model(input logic [31:0] a, input logic [31:0] b, input logic bin);
        logic [32:0] diff;
        longint      sd;
        logic        ov;
        diff = {1'b0, a} - {1'b0, b} - {32'd0, bin};
        sd   = longint'($signed(a)) - longint'($signed(b)) - longint'(bin);
        ov   = (sd > 64'sd2147483647) || (sd < -64'sd2147483648);
        return {ov, diff[31], (diff[31:0] == 32'd0), diff[32], diff[31:0]};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Launch one operation, wait for all three instances, capture results.
    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic bin, input bit pulse);
        bit done [3] = '{1'b0, 1'b0, 1'b0};
        int n = 0;
        a_in     = a;
        b_in     = b;
        bin_in   = bin;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        a_in     = $urandom;
        b_in     = $urandom;
        while (!(done[0] && done[1] && done[2]) && n < 40) begin
            if (pulse && n == 2) begin
                in_valid = 1'b1;
                a_in     = ~a;
            end
            step();
            in_valid = 1'b0;
            n++;
            for (int i = 0; i < 3; i++) begin
                if (!done[i] && out_valid_w[i] === 1'b1) begin
                    done[i]     = 1'b1;
                    lat[i]      = n;
                    cap_d[i]    = d_w[i];
                    cap_bout[i] = bout_w[i];
                    cap_zero[i] = zero_w[i];
                    cap_neg[i]  = neg_w[i];
                    cap_ovf[i]  = ovf_w[i];
                end
            end
        end
        checks++;
        if (!(done[0] && done[1] && done[2])) begin
            failures++;
            $display("FAIL op_timeout: done=%0b%0b%0b after %0d cycles, required all done", done[0], done[1], done[2], n);
            for (int i = 0; i < 3; i++) begin
                if (!done[i]) lat[i] = -1;
            end
        end
    endtask

    // Consume the results; in_ready must be back one cycle later.
    task automatic release_all();
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (in_ready_w[i] !== 1'b1 || out_valid_w[i] !== 1'b0) begin
                failures++;
                $display("FAIL release[%0d]: in_ready=%b out_valid=%b, required 1 0", i, in_ready_w[i], out_valid_w[i]);
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if ({in_ready_w[i], out_valid_w[i], d_w[i], bout_w[i], zero_w[i], neg_w[i], ovf_w[i]} !== {1'b1, 1'b0, 32'd0, 4'b0000}) begin
                failures++;
                $display("FAIL reset[%0d]: rdy=%b vld=%b D=%h flags=%b%b%b%b, required 1 0 0 0000",
                         i, in_ready_w[i], out_valid_w[i], d_w[i], bout_w[i], zero_w[i], neg_w[i], ovf_w[i]);
            end
        end
    endtask

    task automatic test_directed();
        logic [31:0] ta [7] = '{32'h5, 32'h0, 32'h80000000, 32'h7FFFFFFF, 32'h12345678, 32'h12345678, 32'hFFFFFFFF};
        logic [31:0] tb [7] = '{32'h3, 32'h1, 32'h1, 32'hFFFFFFFF, 32'h12345678, 32'h12345678, 32'h0};
        logic        tc [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        logic [35:0] exp;
        for (int t = 0; t < 7; t++) begin
            run_op(ta[t], tb[t], tc[t], 1'b0);
            exp = model(ta[t], tb[t], tc[t]);
            for (int i = 0; i < 3; i++) begin
                checks++;
                if ({cap_ovf[i], cap_neg[i], cap_zero[i], cap_bout[i], cap_d[i]} !== exp) begin
                    failures++;
                    $display("FAIL directed%0d[%0d]: got ovf/neg/zero/bout=%b%b%b%b D=%h, required %b D=%h",
                             t, i, cap_ovf[i], cap_neg[i], cap_zero[i], cap_bout[i], cap_d[i], exp[35:32], exp[31:0]);
                end
                checks++;
                if (lat[i] !== nd_e[i]) begin
                    failures++;
                    $display("FAIL latency%0d[%0d]: got %0d, required %0d", t, i, lat[i], nd_e[i]);
                end
            end
            release_all();
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] a = $urandom;
        logic [31:0] b = $urandom;
        logic [35:0] exp;
        run_op(a, b, 1'b0, 1'b1);
        exp = model(a, b, 1'b0);
        for (int k = 0; k < 5; k++) begin
            step();
            for (int i = 0; i < 3; i++) begin
                checks++;
                if ({out_valid_w[i], in_ready_w[i], ovf_w[i], neg_w[i], zero_w[i], bout_w[i], d_w[i]} !== {2'b10, exp}) begin
                    failures++;
                    $display("FAIL hold%0d[%0d]: vld=%b rdy=%b flags=%b%b%b%b D=%h, required 1 0 %b D=%h",
                             k, i, out_valid_w[i], in_ready_w[i], ovf_w[i], neg_w[i], zero_w[i], bout_w[i], d_w[i],
                             exp[35:32], exp[31:0]);
                end
            end
        end
        release_all();
    endtask

    task automatic test_rst_midrun();
        logic [35:0] exp;
        a_in     = 32'hDEADBEEF;
        b_in     = 32'h01234567;
        bin_in   = 1'b1;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (in_ready_w[i] !== 1'b1 || out_valid_w[i] !== 1'b0 || d_w[i] !== 32'd0) begin
                failures++;
                $display("FAIL midrun_rst[%0d]: rdy=%b vld=%b D=%h, required 1 0 0", i, in_ready_w[i], out_valid_w[i], d_w[i]);
            end
        end
        run_op(32'd10, 32'd4, 1'b0, 1'b0);
        exp = model(32'd10, 32'd4, 1'b0);
        for (int i = 0; i < 3; i++) begin
            checks++;
            if ({cap_ovf[i], cap_neg[i], cap_zero[i], cap_bout[i], cap_d[i]} !== exp) begin
                failures++;
                $display("FAIL after_rst[%0d]: D=%h, required %h", i, cap_d[i], exp[31:0]);
            end
        end
        release_all();
    endtask

    task automatic test_random();
        logic [31:0] a;
        logic [31:0] b;
        logic        c;
        logic [35:0] exp;
        for (int t = 0; t < 1000; t++) begin
            a = $urandom;
            b = ($urandom_range(0, 7) == 0) ? a : 32'($urandom);
            c = 1'($urandom_range(0, 1));
            run_op(a, b, c, 1'b0);
            exp = model(a, b, c);
            for (int i = 0; i < 3; i++) begin
                checks++;
                if ({cap_ovf[i], cap_neg[i], cap_zero[i], cap_bout[i], cap_d[i]} !== exp || lat[i] !== nd_e[i]) begin
                    failures++;
                    $display("FAIL random%0d[%0d]: A=%h B=%h Bin=%b got %b D=%h lat=%0d, required %b D=%h lat=%0d",
                             t, i, a, b, c, {cap_ovf[i], cap_neg[i], cap_zero[i], cap_bout[i]}, cap_d[i], lat[i],
                             exp[35:32], exp[31:0], nd_e[i]);
                end
            end
            release_all();
        end
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a_in      = 32'd0;
        b_in      = 32'd0;
        bin_in    = 1'b0;
        test_reset();
        test_directed();
        test_backpressure();
        test_rst_midrun();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
